// File: rtl/fetch_seq.sv
// fetch_seq -- F-stage sequencer for the five-stage MIPS pipeline.
//
// Owns the fetch PC, issues instruction-memory requests over a ready-based
// handshake, holds the fetched word while D stalls, and applies D-stage
// redirects with delay-slot ordering. A redirect that arrives while its
// delay slot is still being fetched is parked in redir_pc and applied once
// the slot has been consumed.
//
// Optional feature macro: FETCH_ADDR_CHECK_EN
//   defined   : misaligned or out-of-window fetch addresses are not
//               requested; a nop with F_excAdEL=1 is delivered instead.
//   undefined : every address is requested as-is, F_excAdEL stays 0.
//
// Ports:
//   clk         in   clock, all state on rising edge
//   reset       in   asynchronous active-low reset
//   stall       in   D stage cannot accept; F output holds
//   br_taken    in   D-stage redirect valid
//   br_target   in   redirect address
//   imem_req    out  fetch request valid (decoded from state)
//   imem_addr   out  fetch address (= pc_q)
//   imem_ready  in   imem_rdata valid; completes the request
//   imem_rdata  in   fetched instruction word
//   F_valid     out  F_PC/F_instr hold a real instruction
//   F_PC        out  PC of the held instruction
//   F_instr     out  held instruction
//   F_excAdEL   out  fetch address error for the held slot

module fetch_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        F_valid,
  output logic [31:0] F_PC,
  output logic [31:0] F_instr,
  output logic        F_excAdEL
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] ADDR_LO = 32'h0000_3000;
  localparam logic [XLEN-1:0] ADDR_HI = 32'h0000_6FFC;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HAVE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [XLEN-1:0]   fpc_q, fpc_d;
  logic [XLEN-1:0]   redir_pc_q, redir_pc_d;
  logic              redir_pend_q, redir_pend_d;
  logic              valid_q, valid_d;
  logic              exc_q, exc_d;
  logic              addr_bad_c;

  // Fetch-address legality; constant 0 when checking is compiled out.
`ifdef FETCH_ADDR_CHECK_EN
  assign addr_bad_c = (pc_q[1:0] != 2'b00) || (pc_q < ADDR_LO) || (pc_q > ADDR_HI);
`else
  assign addr_bad_c = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RST;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q         <= RESET_PC;
      instr_q      <= '0;
      fpc_q        <= RESET_PC;
      redir_pc_q   <= '0;
      redir_pend_q <= 1'b0;
      valid_q      <= 1'b0;
      exc_q        <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      fpc_q        <= fpc_d;
      redir_pc_q   <= redir_pc_d;
      redir_pend_q <= redir_pend_d;
      valid_q      <= valid_d;
      exc_q        <= exc_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RST:  state_d = ST_WAIT;
      // An illegal address skips the memory and completes immediately.
      ST_WAIT: if (addr_bad_c || imem_ready) state_d = ST_HAVE;
      ST_HAVE: if (!stall) state_d = ST_WAIT;
      default: state_d = ST_RST;
    endcase
  end

  // Output decode and datapath next values.
  always_comb begin
    imem_req     = 1'b0;
    imem_addr    = pc_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    fpc_d        = fpc_q;
    redir_pc_d   = redir_pc_q;
    redir_pend_d = redir_pend_q;
    valid_d      = valid_q;
    exc_d        = exc_q;

    unique case (state_q)
      ST_RST: begin
        pc_d    = RESET_PC;
        valid_d = 1'b0;
        exc_d   = 1'b0;
      end

      ST_WAIT: begin
        imem_req = !addr_bad_c;
        if (addr_bad_c) begin
          instr_d = '0;
          fpc_d   = pc_q;
          valid_d = 1'b1;
          exc_d   = 1'b1;
        end else if (imem_ready) begin
          instr_d = imem_rdata;
          fpc_d   = pc_q;
          valid_d = 1'b1;
          exc_d   = 1'b0;
        end
        // Delay slot not yet delivered: park the redirect. A newer one
        // (branch in a delay slot) simply overwrites the parked target.
        if (br_taken && !stall) begin
          redir_pend_d = 1'b1;
          redir_pc_d   = br_target;
        end
      end

      ST_HAVE: begin
        if (!stall) begin
          valid_d = 1'b0;
          exc_d   = 1'b0;
          if (redir_pend_q) begin
            pc_d         = redir_pc_q;
            redir_pend_d = 1'b0;
          end else if (br_taken) begin
            pc_d = br_target;
          end else begin
            pc_d = pc_q + PC_STEP;
          end
        end
      end

      default: begin
        valid_d = 1'b0;
      end
    endcase
  end

  assign F_valid   = valid_q;
  assign F_PC      = fpc_q;
  assign F_instr   = instr_q;
  assign F_excAdEL = exc_q;

endmodule

// File: doc/fetch_seq.md
# fetch_seq

Fetch-stage sequencer for the five-stage MIPS pipeline. It owns the F-stage PC register, issues instruction-memory requests through a ready-based handshake, holds the fetched instruction under D-stage stalls, and applies branch/jump redirects from the D-stage next-PC logic with correct delay-slot ordering. A redirect that arrives before its delay slot has been fetched is buffered and applied after the delay slot is consumed.

## Interface
- RESET_PC, 32'h0000_3000, first fetch address after reset
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- stall  in  1  D stage cannot accept; F output must hold
- br_taken  in  1  D-stage redirect valid (taken branch, jal, jr)
- br_target  in  32  redirect address from D-stage next-PC logic
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address (= pc_q)
- imem_ready  in  1  imem_rdata valid this cycle; completes the request
- imem_rdata  in  32  fetched instruction word
- F_valid  out  1  F_PC/F_instr hold a real instruction
- F_PC  out  32  PC of held instruction
- F_instr  out  32  held instruction
- F_excAdEL  out  1  fetch address error (see Configuration)

## Operation
- State: pc_q[31:0], instr_q[31:0], state {RST, WAIT, HAVE}, redir_pend, redir_pc[31:0].
- RST: imem_req=0, F_valid=0. Next cycle -> WAIT with pc_q=RESET_PC.
- WAIT: imem_req=1, imem_addr=pc_q, F_valid=0. On imem_ready: instr_q<=imem_rdata -> HAVE. imem_ready outside WAIT is ignored.
- HAVE: F_valid=1, imem_req=0. stall=1: hold everything. stall=0: instruction consumed; pc_q<=next; -> WAIT.
- next priority: redir_pend -> redir_pc (clear redir_pend); else br_taken -> br_target; else pc_q+4 (32-bit wrap, no carry out).
- br_taken honoured only when stall=0. In HAVE: the held instruction is the delay slot; redirect applies directly via next. In WAIT: redir_pend<=1, redir_pc<=br_target; the delay slot is still fetched and delivered. In RST: ignored.
- br_taken while redir_pend=1 (branch in delay slot, architecturally undefined): newer target overwrites redir_pc; bench flags it.
- Simultaneous redirect and imem_ready in WAIT: both captured; -> HAVE with redir_pend=1.
- All arithmetic 32-bit unsigned; br_target used verbatim.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, F_valid=0, F_PC=RESET_PC, F_instr=0, F_excAdEL=0, redir_pend=0, state=RST.
- Reset asserted mid-request: outstanding request abandoned; response arriving after reset release while in RST is dropped.
- Zero-wait imem: request cycle N, F_valid at N+1, next request N+2; throughput one instruction per 2 cycles. Each imem wait state adds one cycle.
- imem_addr stable while imem_req=1; request never withdrawn before imem_ready.
- Outputs are registered except imem_req/imem_addr (decoded from state/pc_q, glitch-free).

## Configuration
- FETCH_ADDR_CHECK_EN defined: on entering WAIT, if pc_q[1:0]!=0 or pc_q outside [0x3000, 0x6FFC], no request is issued; next cycle -> HAVE with instr_q=0 (nop) and F_excAdEL=1, held and consumed like a normal instruction; F_excAdEL clears on consumption.
- Not defined: F_excAdEL tied 0; every address is requested as-is.

## Test plan
- Reset release, imem_ready=1 constant, stall=0 -> imem_addr 0x3000, 0x3004, 0x3008 on alternating cycles; F_PC follows one cycle later with F_valid=1.
- stall=1 for 3 cycles while HAVE at 0x3004 -> F_PC/F_instr/F_valid unchanged, imem_req=0; resumes at 0x3008 after release.
- br_taken=1, target 0x3100, in HAVE with delay slot 0x3008 held -> slot delivered, next imem_addr 0x3100.
- Same branch while WAIT at 0x3008 with imem_ready held 0 for 2 cycles -> redir_pend=1, 0x3008 delivered, then fetch 0x3100; 0x300C never requested.
- Reset asserted during WAIT with imem_ready pulsing -> all outputs at reset values immediately; refetch from 0x3000.
- With FETCH_ADDR_CHECK_EN, jr to 0x3002 -> no request for 0x3002, F_instr=0, F_excAdEL=1 for that slot; without macro -> imem_addr 0x3002 requested.
